fpr_cdb_arbiter: RTL and testbench

Grants the floating-point common data bus (FPR CDB) to one of N execution-unit requesters per cycle and broadcasts the winner's tag and result as `fpr_cdb` one cycle later. It is the responder end of the `fpr_cdb_req` valid/ready handshake that every FP unit (fmov, fadd, fmul, ...) drives. Its `fpr_cdb` output feeds back into all reservation stations, the ROB and the FPR rename logic.

---
 rtl/fpr_cdb_arbiter_pkg.sv | 19 +
 rtl/fpr_cdb_arbiter_rr_arbiter.sv | 39 +++
 rtl/fpr_cdb_arbiter.sv | 76 +++++++
 tb/tb_fpr_cdb_arbiter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared CDB types and helpers used by the FP and integer result buses.
// Holds the broadcast record, the ROB tag width and the tag comparator that consumers use.
package fpr_cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 6;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic                  valid;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_t;

  // Reservation stations wake up only on a valid broadcast carrying their tag.
  function automatic logic tag_match(input cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
    return cdb.valid && (cdb.tag == tag);
  endfunction

endpackage

// File: rtl/fpr_cdb_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: the first set request at or after ptr wins.
// Shared by the FP and integer CDB arbiters.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  localparam int SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] idx;

  // NOTE: every output gets a default before the scan so no path leaves it unassigned (no latch).
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      // ptr < N and k < N, so one conditional subtraction implements the wrap.
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      idx = sum[IW-1:0];
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FP common data bus arbiter: same-cycle round-robin grant, one-cycle-later broadcast
// of the winner's tag, with data muxed live from the winner's result register.
module fpr_cdb_arbiter
  import fpr_cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [ROB_WIDTH-1:0]  req_tag    [N_REQ],
  input  logic [DATA_WIDTH-1:0] req_result [N_REQ],
  output cdb_t                  fpr_cdb
);

  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        gnt_idx_q, gnt_idx_d;
  logic [ROB_WIDTH-1:0] gnt_tag_q, gnt_tag_d;
  logic                 gnt_v_q, gnt_v_d;

  logic [N_REQ-1:0] req_masked;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  // Requests are masked while reset is high so no unit believes it dispatched.
  assign req_masked = reset ? '0 : req_valid;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req     (req_masked),
    .ptr     (ptr_q),
    .gnt     (req_ready),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_tag_d = gnt_tag_q;
    gnt_v_d   = arb_any;
    if (arb_any) begin
      ptr_d     = (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      gnt_idx_d = arb_idx;
      gnt_tag_d = req_tag[arb_idx];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_tag_q <= '0;
      gnt_v_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_tag_q <= gnt_tag_d;
      gnt_v_q   <= gnt_v_d;
    end
  end

  // The winner registered its result on the grant edge, so the data mux is combinational.
  always_comb begin
    fpr_cdb.valid = gnt_v_q;
    fpr_cdb.tag   = gnt_tag_q;
    fpr_cdb.data  = req_result[gnt_idx_q];
  end

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Directed bench for fpr_cdb_arbiter: stimulus pushes expected broadcasts into a
// scoreboard queue, and a negedge monitor pops and compares each one.
module tb_fpr_cdb_arbiter;
  import fpr_cdb_arbiter_pkg::*;

  localparam int N = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_ready;
  logic [ROB_WIDTH-1:0]  req_tag    [N];
  logic [DATA_WIDTH-1:0] req_result [N];
  cdb_t                  fpr_cdb;

  fpr_cdb_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .req_result (req_result),
    .fpr_cdb    (fpr_cdb)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                    due;
    int                    unit;
    logic [ROB_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [ROB_WIDTH-1:0]  tags [N];
  logic [DATA_WIDTH-1:0] res  [N];
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // One request cycle: drive after the edge, check the same-cycle grant, record the broadcast.
  task automatic step(input logic [N-1:0] valid, input logic [N-1:0] exp_ready, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst;
    req_valid = valid;
    for (int i = 0; i < N; i++) req_tag[i] = tags[i];
    #1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    for (int i = 0; i < N; i++) begin
      if (exp_ready[i]) begin
        e.due  = cyc + 1;
        e.unit = i;
        e.tag  = tags[i];
        e.data = res[i];
        exp_q.push_back(e);
      end
    end
  endtask

  // Monitor: every valid broadcast must match the oldest expectation; a due entry must not be skipped.
  always @(negedge clk) begin
    exp_t e;
    if (reset !== 1'b1 || fpr_cdb.valid === 1'b1) begin
      if (fpr_cdb.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 64'(fpr_cdb.valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("cdb_cycle", 64'(cyc), 64'(e.due));
          check("cdb_tag", 64'(fpr_cdb.tag), 64'(e.tag));
          check("cdb_data", 64'(fpr_cdb.data), 64'(e.data));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_broadcast_unit", 64'(fpr_cdb.valid), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
    end
  end

  initial begin
    res[0] = 32'h1111_AAAA;
    res[1] = 32'h2222_BBBB;
    res[2] = 32'h3333_CCCC;
    res[3] = 32'h4444_DDDD;
    for (int i = 0; i < N; i++) begin
      tags[i]       = '0;
      req_tag[i]    = '0;
      req_result[i] = res[i];
    end
    reset     = 1'b1;
    req_valid = '0;

    // Reset with requests high: no grant may be given.
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b0000, 4'b0000, 1'b1);
    @(negedge clk);
    check("reset_valid", 64'(fpr_cdb.valid), 64'd0);

    // Only unit 2 with tag 5: ptr moves to 3.
    tags[2] = 6'd5;
    step(4'b0100, 4'b0100, 1'b0);

    // Only unit 3 for three cycles: back-to-back grants, ptr wraps to 0 each time.
    tags[3] = 6'd7;
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b1000, 1'b0);

    // All units with tags 1..4 from ptr 0: rotation 0,1,2,3,0.
    tags[0] = 6'd1; tags[1] = 6'd2; tags[2] = 6'd3; tags[3] = 6'd4;
    step(4'b1111, 4'b0001, 1'b0);
    step(4'b1111, 4'b0010, 1'b0);
    step(4'b1111, 4'b0100, 1'b0);
    step(4'b1111, 4'b1000, 1'b0);
    step(4'b1111, 4'b0001, 1'b0);

    // Units 0 and 1 with ptr 1: unit 1, then wrap to unit 0.
    step(4'b0011, 4'b0010, 1'b0);
    step(4'b0011, 4'b0001, 1'b0);

    // Idle cycles must leave ptr at 1: units 0 and 2 then resolve to 2, then 0.
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0101, 4'b0100, 1'b0);
    step(4'b0101, 4'b0001, 1'b0);

    // Grant to unit 1, then reset: that broadcast still appears, the next cycle is quiet.
    tags[1] = 6'd9;
    step(4'b1111, 4'b0010, 1'b0);
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    tags[0] = 6'd12;
    step(4'b1111, 4'b0001, 1'b0);
    step(4'b1111, 4'b0010, 1'b0);

    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
